// File: rtl/uart_word_tx.sv
// Purpose: serialises a DATA_BITS word as back-to-back UART frames (optional parity, 1/2 stop bits, selectable byte order).
// Latency: start bit begins the cycle after the handshake; done_o pulses the cycle after the last stop bit ends.
// Backpressure: ready_o is low for the whole word; valid_i is ignored and data_i is not sampled while ready_o is low.
module uart_word_tx #(
    parameter int DATA_BITS = 24,
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 50000000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int NBYTES   = DATA_BITS / 8;
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int BYTE_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
    localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);

    // Reject configurations the datapath cannot represent.
    if ((DATA_BITS % 8) != 0 || DATA_BITS < 8 || DATA_BITS > 64) begin : g_bad_width
        $fatal(1, "uart_word_tx: DATA_BITS must be a multiple of 8 in 8..64");
    end
    if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
        $fatal(1, "uart_word_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_word_tx: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud
        $fatal(1, "uart_word_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic [7:0]          sh_q, sh_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          cur_byte;
    logic                bit_end;

    // The word register is shifted so the next byte to send always sits at the chosen end.
    assign cur_byte = (MSB_FIRST != 0) ? word_q[DATA_BITS-1 -: 8] : word_q[7:0];
    assign bit_end  = (cnt_q == '0);

    assign ready_o = ready_q;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    // State register and all datapath registers; tx_o is registered so the line never glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; every line bit lasts BAUD_DIV cycles of the down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? CNT_LOAD : cnt_q - CNT_ONE;
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
                cnt_d   = CNT_LOAD;
                bit_d   = '0;
                byte_d  = '0;
                if (valid_i && ready_q) begin
                    word_d  = data_i;
                    state_d = START;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    sh_d    = cur_byte;
                    par_d   = (PARITY == 1) ? ~^cur_byte : ^cur_byte;
                    word_d  = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q != LAST_STOP) begin
                        bit_d = bit_q + 3'd1;
                    end else if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        // Next frame starts immediately after the last stop-bit cycle.
                        byte_d  = byte_q + BYTE_ONE;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Purpose: directed self-checking bench for uart_word_tx across four parameter sets.
// Latency: checks every line cycle against a frame model built from hand-written byte sequences.
// Backpressure: exercises held valid, valid while busy, and reset in the middle of a word.
module tb_uart_word_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [23:0] d0, d3;
    logic [7:0]  d1, d2;
    logic [3:0] rdy, txl, bsy, dn;
    logic [1:0] sel;
    logic       tx_m, rdy_m, bsy_m, dn_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Route the currently tested instance's outputs to common monitor signals.
    always_comb begin
        tx_m  = txl[sel];
        rdy_m = rdy[sel];
        bsy_m = bsy[sel];
        dn_m  = dn[sel];
    end

    uart_word_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) u_def (
        .clk_i(clk), .rst_i(rst), .data_i(d0), .valid_i(vld[0]),
        .ready_o(rdy[0]), .tx_o(txl[0]), .busy_o(bsy[0]), .done_o(dn[0]));

    uart_word_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2)) u_even (
        .clk_i(clk), .rst_i(rst), .data_i(d1), .valid_i(vld[1]),
        .ready_o(rdy[1]), .tx_o(txl[1]), .busy_o(bsy[1]), .done_o(dn[1]));

    uart_word_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1)) u_odd (
        .clk_i(clk), .rst_i(rst), .data_i(d2), .valid_i(vld[2]),
        .ready_o(rdy[2]), .tx_o(txl[2]), .busy_o(bsy[2]), .done_o(dn[2]));

    uart_word_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .MSB_FIRST(1), .STOP_BITS(2)) u_msb (
        .clk_i(clk), .rst_i(rst), .data_i(d3), .valid_i(vld[3]),
        .ready_o(rdy[3]), .tx_o(txl[3]), .busy_o(bsy[3]), .done_o(dn[3]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int s, input logic v, input logic [23:0] w);
        case (s)
            0: begin vld[0] = v; d0 = w; end
            1: begin vld[1] = v; d1 = w[7:0]; end
            2: begin vld[2] = v; d2 = w[7:0]; end
            default: begin vld[3] = v; d3 = w; end
        endcase
    endtask

    // Wait (bounded) for ready, present the word, and let the handshake edge pass.
    task automatic send(input int s, input logic [23:0] w, input bit hold);
        int n;
        n   = 0;
        sel = 2'(s);
        @(negedge clk);
        while (!rdy_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", rdy_m, 1);
        set_in(s, 1'b1, w);
        @(posedge clk);
        #1;
        if (!hold) set_in(s, 1'b0, w);
    endtask

    // Follow one word from the cycle after the handshake to the done cycle.
    // eb holds the expected bytes in transmission order, byte 0 in bits [7:0].
    task automatic watch(input int nb, input int par, input int stp, input logic [63:0] eb,
                         output int hi_run, output logic last_par);
        int fl, tt, b, fi, pos, errs, dones, run;
        logic [63:0] dec;
        logic [7:0]  by;
        logic        ex, t;
        fl = 9 + ((par != 0) ? 1 : 0) + stp;
        tt = nb * fl * 10;
        errs = 0; dones = 0; run = 0; dec = '0; last_par = 1'bx;
        for (int k = 0; k <= tt; k++) begin
            @(negedge clk);
            t = tx_m;
            if (k == 0) begin
                check_eq("start_busy", bsy_m, 1);
                check_eq("start_ready", rdy_m, 0);
            end
            if (k == tt) begin
                check_eq("done", dn_m, 1);
                check_eq("done_ready", rdy_m, 1);
                check_eq("done_busy", bsy_m, 0);
                check_eq("done_tx", t, 1);
            end else begin
                b   = k / 10;
                fi  = b / fl;
                pos = b % fl;
                by  = eb[8*fi +: 8];
                if (pos == 0) ex = 1'b0;
                else if (pos <= 8) ex = by[pos-1];
                else if (pos == 9 && par != 0) ex = (par == 2) ? ^by : ~^by;
                else ex = 1'b1;
                if (t !== ex) errs++;
                if (dn_m) dones++;
                if (k % 10 == 5) begin
                    if (pos >= 1 && pos <= 8) dec[8*fi + pos - 1] = t;
                    else if (pos == 9 && par != 0) last_par = t;
                end
                run = t ? run + 1 : 0;
            end
        end
        check_eq("line", errs, 0);
        check_eq("early_done", dones, 0);
        for (int i = 0; i < nb; i++) check_eq($sformatf("byte%0d", i), dec[8*i +: 8], eb[8*i +: 8]);
        hi_run = run;
    endtask

    // Directed sequence: reset, each configuration, back-to-back, ignored valid, mid-word reset.
    initial begin
        int   run, dc, lc;
        logic p;
        rst = 1'b1; vld = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0; sel = 2'd0;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx_m, 1);
        check_eq("rst_ready", rdy_m, 0);
        check_eq("rst_busy", bsy_m, 0);
        check_eq("rst_done", dn_m, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", rdy_m, 1);

        // 24-bit LSB-first: bytes 3C, C3, A5; T=300.
        send(0, 24'hA5C33C, 1'b0);
        watch(3, 0, 1, 64'hA5C33C, run, p);

        // 8-bit even parity on 0x07: parity bit 1, 110-cycle frame.
        send(1, 24'h000007, 1'b0);
        watch(1, 2, 1, 64'h07, run, p);
        check_eq("even_par", p, 1);

        // 8-bit odd parity on 0x07: parity bit 0.
        send(2, 24'h000007, 1'b0);
        watch(1, 1, 1, 64'h07, run, p);
        check_eq("odd_par", p, 0);

        // MSB-first, two stop bits: bytes 12, 34, 56; T=330; 20 high cycles before done.
        send(3, 24'h123456, 1'b0);
        watch(3, 0, 2, 64'h563412, run, p);
        check_eq("stop2_high", run, 20);

        // valid held high: second word accepted in the done cycle, starts the cycle after.
        send(0, 24'h000001, 1'b1);
        set_in(0, 1'b1, 24'h0000FF);
        watch(3, 0, 1, 64'h000001, run, p);
        check_eq("gap_high", run, 10);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 24'h000000);
        watch(3, 0, 1, 64'h0000FF, run, p);

        // valid pulsed with FFFFFF while busy must be ignored.
        send(0, 24'h5A0F81, 1'b0);
        fork
            watch(3, 0, 1, 64'h5A0F81, run, p);
            begin
                repeat (50) @(negedge clk);
                set_in(0, 1'b1, 24'hFFFFFF);
                @(negedge clk);
                set_in(0, 1'b0, 24'h000000);
            end
        join
        dc = 0; lc = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn_m) dc++;
            if (!tx_m) lc++;
        end
        check_eq("ignored_done", dc, 0);
        check_eq("ignored_low", lc, 0);

        // Reset for two cycles during the second byte.
        send(0, 24'h112233, 1'b0);
        repeat (135) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx", tx_m, 1);
        check_eq("midrst_ready", rdy_m, 0);
        check_eq("midrst_busy", bsy_m, 0);
        check_eq("midrst_done", dn_m, 0);
        @(negedge clk);
        check_eq("midrst_ready2", rdy_m, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("release_ready", rdy_m, 1);
        dc = 0; lc = 0;
        repeat (200) begin
            @(negedge clk);
            if (dn_m) dc++;
            if (!tx_m) lc++;
        end
        check_eq("midrst_no_done", dc, 0);
        check_eq("midrst_idle", lc, 0);
        send(0, 24'hCAFE01, 1'b0);
        watch(3, 0, 1, 64'hCAFE01, run, p);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
